// File: rtl/kbd_pkg.sv
// Shared definitions for the key event arbiter: FSM encoding and default sizing.
package kbd_pkg;

  localparam int unsigned DefN         = 4;
  localparam int unsigned DefIdw       = 2;
  localparam int unsigned DefGapCycles = 2;
  localparam int unsigned GapW         = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOffer = 2'd1,
    StGap   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set pending bit at or above i_rr_ptr, wrapping at N-1 to 0.
module rr_pick
  import kbd_pkg::*;
#(
  parameter int unsigned N   = DefN,
  parameter int unsigned IDW = DefIdw
) (
  input  logic [N-1:0]   i_pending,
  input  logic [IDW-1:0] i_rr_ptr,
  output logic           o_any,
  output logic [IDW-1:0] o_idx
);

  always_comb begin
    int unsigned j;
    j     = 0;
    o_any = 1'b0;
    o_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Explicit wrap so non-power-of-two N never lands on a nonexistent key.
      j = 32'(i_rr_ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (!o_any && i_pending[IDW'(j)]) begin
        o_any = 1'b1;
        o_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Serialises one-cycle key pulses into a valid/ready event stream with round-robin
// arbitration, a post-accept idle gap and sticky per-key overflow flags.
module key_event_arbiter
  import kbd_pkg::*;
#(
  parameter int unsigned N          = DefN,
  parameter int unsigned IDW        = DefIdw,
  parameter int unsigned GAP_CYCLES = DefGapCycles
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_key_pulse,
  input  logic           i_evt_ready,
  input  logic           i_ovf_clr,
  output logic           o_evt_valid,
  output logic [IDW-1:0] o_evt_id,
  output logic [N-1:0]   o_ovf,
  output logic           o_busy
);

  localparam logic [IDW-1:0]  LastId  = IDW'(N - 1);
  localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

  state_e          r_state, w_state_d;
  logic [N-1:0]    r_pending, w_pending_d;
  logic [N-1:0]    r_ovf, w_ovf_d;
  logic [IDW-1:0]  r_evt_id, w_evt_id_d;
  logic [IDW-1:0]  r_rr_ptr, w_rr_ptr_d;
  logic [GapW-1:0] r_gap_cnt, w_gap_cnt_d;

  logic            w_accept;
  logic [N-1:0]    w_clr;
  logic [N-1:0]    w_ovf_set;
  logic            w_any;
  logic [IDW-1:0]  w_pick;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .i_pending (r_pending),
    .i_rr_ptr  (r_rr_ptr),
    .o_any     (w_any),
    .o_idx     (w_pick)
  );

  // A press landing on the key being accepted replaces it rather than overflowing.
  always_comb begin
    w_accept = (r_state == StOffer) && i_evt_ready;
    w_clr    = '0;
    if (w_accept) begin
      w_clr[r_evt_id] = 1'b1;
    end
    w_ovf_set   = r_pending & i_key_pulse & ~w_clr;
    w_pending_d = (r_pending & ~w_clr) | i_key_pulse;
    w_ovf_d     = (i_ovf_clr ? '0 : r_ovf) | w_ovf_set;
  end

  always_comb begin
    w_state_d   = r_state;
    w_evt_id_d  = r_evt_id;
    w_rr_ptr_d  = r_rr_ptr;
    w_gap_cnt_d = r_gap_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_evt_id_d = w_pick;
          w_state_d  = StOffer;
        end
      end
      StOffer: begin
        if (w_accept) begin
          w_rr_ptr_d = (r_evt_id == LastId) ? '0 : r_evt_id + 1'b1;
          if (GAP_CYCLES > 0) begin
            w_gap_cnt_d = GapLoad;
            w_state_d   = StGap;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (r_gap_cnt == '0) begin
          w_state_d = StIdle;
        end else begin
          w_gap_cnt_d = r_gap_cnt - 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_pending <= '0;
      r_ovf     <= '0;
      r_evt_id  <= '0;
      r_rr_ptr  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
      r_ovf     <= w_ovf_d;
      r_evt_id  <= w_evt_id_d;
      r_rr_ptr  <= w_rr_ptr_d;
      r_gap_cnt <= w_gap_cnt_d;
    end
  end

  assign o_evt_valid = (r_state == StOffer);
  assign o_evt_id    = r_evt_id;
  assign o_ovf       = r_ovf;
  assign o_busy      = (r_state != StIdle) || (|r_pending);

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench: one instance with the default gap of 2, one with no gap.
module tb_key_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_pulse = '0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic       v2, busy2, v0, busy0;
  logic [1:0] id2, id0;
  logic [3:0] ovf2, ovf0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  key_event_arbiter #(.N(4), .IDW(2), .GAP_CYCLES(2)) dut_g2 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_key_pulse (key_pulse),
    .i_evt_ready (evt_ready),
    .i_ovf_clr   (ovf_clr),
    .o_evt_valid (v2),
    .o_evt_id    (id2),
    .o_ovf       (ovf2),
    .o_busy      (busy2)
  );

  key_event_arbiter #(.N(4), .IDW(2), .GAP_CYCLES(0)) dut_g0 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_key_pulse (key_pulse),
    .i_evt_ready (evt_ready),
    .i_ovf_clr   (ovf_clr),
    .o_evt_valid (v0),
    .o_evt_id    (id0),
    .o_ovf       (ovf0),
    .o_busy      (busy0)
  );

  // Advance one cycle; outputs are then stable for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_pulse = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", v2); end
    total++; if (id2 !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", id2); end
    total++; if (ovf2 !== 4'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0000", ovf2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy2); end
  endtask

  task automatic test_single_press();
    do_reset();
    evt_ready = 1'b1;
    step(); step();
    key_pulse = 4'b0100;
    step();
    key_pulse = '0;
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL single_t1_valid got=%0b want=0", v2); end
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL single_t1_busy got=%0b want=1", busy2); end
    step();
    total++; if (v2 !== 1'b1) begin bad++; $display("FAIL single_t2_valid got=%0b want=1", v2); end
    total++; if (id2 !== 2'd2) begin bad++; $display("FAIL single_t2_id got=%0d want=2", id2); end
    step();
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL single_gap1_valid got=%0b want=0", v2); end
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL single_gap1_busy got=%0b want=1", busy2); end
    step();
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL single_gap2_valid got=%0b want=0", v2); end
    step();
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%0b want=0", v2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%0b want=0", busy2); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ids [3];
    exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd3;
    do_reset();
    evt_ready = 1'b1;
    key_pulse = 4'b1011;
    step();
    key_pulse = '0;
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL b2b_t1_valid got=%0b want=0", v0); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (v0 !== 1'b1) begin bad++; $display("FAIL b2b_offer%0d_valid got=%0b want=1", i, v0); end
      total++; if (id0 !== exp_ids[i]) begin bad++; $display("FAIL b2b_offer%0d_id got=%0d want=%0d", i, id0, exp_ids[i]); end
      step();
      total++; if (v0 !== 1'b0) begin bad++; $display("FAIL b2b_idle%0d_valid got=%0b want=0", i, v0); end
    end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL b2b_end_busy got=%0b want=0", busy0); end
    // Pointer wrapped to 0, so key 0 beats key 3.
    key_pulse = 4'b1001;
    step();
    key_pulse = '0;
    step();
    total++; if (v0 !== 1'b1) begin bad++; $display("FAIL b2b_wrap_valid got=%0b want=1", v0); end
    total++; if (id0 !== 2'd0) begin bad++; $display("FAIL b2b_wrap_id got=%0d want=0", id0); end
  endtask

  task automatic test_stall();
    do_reset();
    evt_ready = 1'b0;
    key_pulse = 4'b0010;
    step();
    key_pulse = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) key_pulse = 4'b1000;
      total++; if (v2 !== 1'b1) begin bad++; $display("FAIL stall%0d_valid got=%0b want=1", i, v2); end
      total++; if (id2 !== 2'd1) begin bad++; $display("FAIL stall%0d_id got=%0d want=1", i, id2); end
      step();
      key_pulse = '0;
    end
    total++; if (id2 !== 2'd1) begin bad++; $display("FAIL stall_end_id got=%0d want=1", id2); end
    evt_ready = 1'b1;
    step(); step(); step();
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL stall_idle_valid got=%0b want=0", v2); end
    step();
    total++; if (v2 !== 1'b1) begin bad++; $display("FAIL stall_next_valid got=%0b want=1", v2); end
    total++; if (id2 !== 2'd3) begin bad++; $display("FAIL stall_next_id got=%0d want=3", id2); end
    total++; if (ovf2 !== 4'b0) begin bad++; $display("FAIL stall_ovf got=%b want=0000", ovf2); end
  endtask

  task automatic test_overflow();
    do_reset();
    evt_ready = 1'b0;
    key_pulse = 4'b0100;
    step();
    total++; if (ovf2 !== 4'b0) begin bad++; $display("FAIL ovf_first_press got=%b want=0000", ovf2); end
    step();
    key_pulse = '0;
    total++; if (ovf2 !== 4'b0100) begin bad++; $display("FAIL ovf_second_press got=%b want=0100", ovf2); end
    ovf_clr = 1'b1;
    key_pulse = 4'b0100;
    step();
    ovf_clr = 1'b0;
    key_pulse = '0;
    total++; if (ovf2 !== 4'b0100) begin bad++; $display("FAIL ovf_set_beats_clr got=%b want=0100", ovf2); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total++; if (ovf2 !== 4'b0) begin bad++; $display("FAIL ovf_clr_alone got=%b want=0000", ovf2); end
  endtask

  task automatic test_collision();
    do_reset();
    evt_ready = 1'b1;
    key_pulse = 4'b0010;
    step();
    key_pulse = '0;
    step();
    total++; if (v2 !== 1'b1 || id2 !== 2'd1) begin bad++; $display("FAIL coll_offer got=%0b/%0d want=1/1", v2, id2); end
    key_pulse = 4'b0010;
    step();
    key_pulse = '0;
    total++; if (ovf2 !== 4'b0) begin bad++; $display("FAIL coll_ovf got=%b want=0000", ovf2); end
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL coll_busy got=%0b want=1", busy2); end
    step(); step();
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL coll_idle_valid got=%0b want=0", v2); end
    step();
    total++; if (v2 !== 1'b1) begin bad++; $display("FAIL coll_reoffer_valid got=%0b want=1", v2); end
    total++; if (id2 !== 2'd1) begin bad++; $display("FAIL coll_reoffer_id got=%0d want=1", id2); end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    evt_ready = 1'b0;
    key_pulse = 4'b1110;
    step();
    key_pulse = 4'b0010;
    step();
    key_pulse = '0;
    total++; if (v2 !== 1'b1 || id2 !== 2'd1) begin bad++; $display("FAIL rmo_offer got=%0b/%0d want=1/1", v2, id2); end
    total++; if (ovf2 !== 4'b0010) begin bad++; $display("FAIL rmo_pre_ovf got=%b want=0010", ovf2); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL rmo_valid got=%0b want=0", v2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rmo_busy got=%0b want=0", busy2); end
    total++; if (ovf2 !== 4'b0) begin bad++; $display("FAIL rmo_ovf got=%b want=0000", ovf2); end
    total++; if (id2 !== 2'd0) begin bad++; $display("FAIL rmo_id got=%0d want=0", id2); end
    key_pulse = 4'b1000;
    step();
    key_pulse = '0;
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL rmo_t1_valid got=%0b want=0", v2); end
    step();
    total++; if (v2 !== 1'b1 || id2 !== 2'd3) begin bad++; $display("FAIL rmo_new_offer got=%0b/%0d want=1/3", v2, id2); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_collision();
    test_reset_mid_offer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
